// File: rtl/halloween_fx_sequencer.sv
// Opcode sequencer for the decoration: decodes 4-bit commands from the mux stage and drives
// power, colour, timed sound and timed effect outputs behind a one-entry pending register.
module halloween_fx_sequencer #(
    parameter int SOUND_CYCLES = 8,
    parameter int FX_CYCLES    = 4,
    parameter int FOG_CYCLES   = 12,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [3:0]       opcode,
    output logic             op_ready,
    output logic             powered,
    output logic             color_en,
    output logic [1:0]       color_sel,
    output logic             sound_en,
    output logic [1:0]       sound_sel,
    output logic [2:0]       fx_en,
    output logic             bad_op,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int FX_MAX = (FOG_CYCLES > FX_CYCLES) ? FOG_CYCLES : FX_CYCLES;
    localparam int SND_W  = $clog2(SOUND_CYCLES + 1);
    localparam int FX_W   = $clog2(FX_MAX + 1);
    localparam logic [SND_W-1:0] SND_LOAD = SND_W'(SOUND_CYCLES - 1);
    localparam logic [FX_W-1:0]  FX_LOAD  = FX_W'(FX_CYCLES - 1);
    localparam logic [FX_W-1:0]  FOG_LOAD = FX_W'(FOG_CYCLES - 1);

    typedef enum logic {ST_OFF, ST_ON} state_t;

    state_t           state, state_next;
    logic             rdy_q;
    logic             pend_v;
    logic [3:0]       pend_op;
    logic [SND_W-1:0] snd_cnt;
    logic [FX_W-1:0]  fx_cnt;

    logic [1:0] cat, opd;
    logic       undef_op, pend_busy, pend_fire, accept;
    logic       do_off, do_color, do_sound, do_fx, do_drop;

    assign cat      = pend_op[3:2];
    assign opd      = pend_op[1:0];
    assign undef_op = (cat == 2'b00) ? opd[1] : (opd == 2'b11);

    // Busy depends only on registered state, so op_ready never depends on op_valid.
    assign pend_busy = !undef_op &&
                       (((cat == 2'b10) && sound_en) || ((cat == 2'b11) && (fx_en != 3'b000)));
    assign pend_fire = pend_v && !pend_busy;
    assign op_ready  = rdy_q && (!pend_v || pend_fire);
    assign accept    = op_valid && op_ready;
    assign powered   = (state == ST_ON);

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        state_next = state;
        do_off     = 1'b0;
        do_color   = 1'b0;
        do_sound   = 1'b0;
        do_fx      = 1'b0;
        do_drop    = 1'b0;
        if (pend_fire) begin
            if (undef_op) begin
                do_drop = 1'b1;
            end else if (state == ST_OFF) begin
                if (pend_op == 4'b0000)      state_next = ST_ON;
                else if (pend_op != 4'b0001) do_drop    = 1'b1;
            end else begin
                case (cat)
                    2'b00: if (opd == 2'b01) begin
                        state_next = ST_OFF;
                        do_off     = 1'b1;
                    end
                    2'b01:   do_color = 1'b1;
                    2'b10:   do_sound = 1'b1;
                    default: do_fx    = 1'b1;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_OFF;
            rdy_q   <= 1'b0;
            pend_v  <= 1'b0;
            pend_op <= 4'b0000;
        end else begin
            state <= state_next;
            rdy_q <= 1'b1;
            if (accept) begin
                pend_v  <= 1'b1;
                pend_op <= opcode;
            end else if (pend_fire) begin
                pend_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_en  <= 1'b0;
            color_sel <= 2'b00;
        end else if (do_off) begin
            color_en  <= 1'b0;
            color_sel <= 2'b00;
        end else if (do_color) begin
            color_en  <= 1'b1;
            color_sel <= opd;
        end
    end

    // Down-counter loaded with N-1: the enable stays high for exactly N clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sound_en  <= 1'b0;
            sound_sel <= 2'b00;
            snd_cnt   <= '0;
        end else if (do_off) begin
            sound_en  <= 1'b0;
            sound_sel <= 2'b00;
            snd_cnt   <= '0;
        end else if (do_sound) begin
            sound_en  <= 1'b1;
            sound_sel <= opd;
            snd_cnt   <= SND_LOAD;
        end else if (sound_en) begin
            if (snd_cnt == '0) sound_en <= 1'b0;
            else               snd_cnt  <= snd_cnt - SND_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fx_en  <= 3'b000;
            fx_cnt <= '0;
        end else if (do_off) begin
            fx_en  <= 3'b000;
            fx_cnt <= '0;
        end else if (do_fx) begin
            fx_en  <= 3'b001 << opd;
            fx_cnt <= (opd == 2'b10) ? FOG_LOAD : FX_LOAD;
        end else if (fx_en != 3'b000) begin
            if (fx_cnt == '0) fx_en  <= 3'b000;
            else              fx_cnt <= fx_cnt - FX_W'(1);
        end
    end

    // Drop count survives a RESET command; only rst_n clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_op   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            bad_op <= do_drop;
            if (do_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_halloween_fx_sequencer.sv
// Self-checking bench for halloween_fx_sequencer: table-driven single commands plus
// scoreboard-traced multi-cycle sequences for sound, effects, RESET and saturation.
module tb_halloween_fx_sequencer;
    localparam int SOUND_CYCLES = 8;
    localparam int FX_CYCLES    = 4;
    localparam int FOG_CYCLES   = 12;
    localparam int CNT_W        = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             op_valid;
    logic [3:0]       opcode;
    logic             op_ready;
    logic             powered;
    logic             color_en;
    logic [1:0]       color_sel;
    logic             sound_en;
    logic [1:0]       sound_sel;
    logic [2:0]       fx_en;
    logic             bad_op;
    logic [CNT_W-1:0] drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] op;
        logic       pw;
        logic       cen;
        logic [1:0] csel;
        logic       bad;
        logic [7:0] drop;
    } vec_t;

    typedef struct {
        logic       s_en;
        logic [1:0] s_sel;
        logic [2:0] fx;
        logic       rdy;
    } trace_t;

    vec_t   vecs[11];
    vec_t   vq[$];
    trace_t tq[$];

    halloween_fx_sequencer #(
        .SOUND_CYCLES(SOUND_CYCLES),
        .FX_CYCLES   (FX_CYCLES),
        .FOG_CYCLES  (FOG_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .opcode   (opcode),
        .op_ready (op_ready),
        .powered  (powered),
        .color_en (color_en),
        .color_sel(color_sel),
        .sound_en (sound_en),
        .sound_sel(sound_sel),
        .fx_en    (fx_en),
        .bad_op   (bad_op),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents op, waits (bounded) for op_ready, returns 1 time unit after the accepting edge.
    task automatic issue(input logic [3:0] op);
        int n = 0;
        op_valid = 1'b1;
        opcode   = op;
        while (!op_ready && n < 200) begin
            tick();
            n++;
        end
        check("op_ready_wait", 32'(op_ready), 32'd1);
        tick();
        op_valid = 1'b0;
    endtask

    task automatic run_trace(input string tag);
        trace_t e;
        int k = 0;
        while (tq.size() > 0) begin
            e = tq.pop_front();
            check($sformatf("%s_sound_en_k%0d", tag, k), 32'(sound_en), 32'(e.s_en));
            check($sformatf("%s_sound_sel_k%0d", tag, k), 32'(sound_sel), 32'(e.s_sel));
            check($sformatf("%s_fx_en_k%0d", tag, k), 32'(fx_en), 32'(e.fx));
            check($sformatf("%s_op_ready_k%0d", tag, k), 32'(op_ready), 32'(e.rdy));
            tick();
            k++;
        end
    endtask

    initial begin
        vec_t e;

        // op, powered, color_en, color_sel, bad_op, drop_cnt after the firing edge
        vecs[0]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 1'b1, 8'd1};
        vecs[1]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 8'd1};
        vecs[2]  = '{4'b0110, 1'b1, 1'b1, 2'd2, 1'b0, 8'd1};
        vecs[3]  = '{4'b0101, 1'b1, 1'b1, 2'd1, 1'b0, 8'd1};
        vecs[4]  = '{4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 8'd1};
        vecs[5]  = '{4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 8'd2};
        vecs[6]  = '{4'b0111, 1'b1, 1'b1, 2'd1, 1'b1, 8'd3};
        vecs[7]  = '{4'b0011, 1'b1, 1'b1, 2'd1, 1'b1, 8'd4};
        vecs[8]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 8'd4};
        vecs[9]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 8'd4};
        vecs[10] = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 8'd4};

        rst_n    = 1'b0;
        op_valid = 1'b0;
        opcode   = 4'b0000;
        #12;
        check("rst_op_ready", 32'(op_ready), 32'd0);
        check("rst_outputs", 32'({powered, color_en, color_sel, sound_en, sound_sel, fx_en, bad_op}), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("release_op_ready", 32'(op_ready), 32'd1);

        // Single commands, one at a time, each checked one edge after acceptance.
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op);
            vq.push_back(vecs[i]);
            tick();
            e = vq.pop_front();
            check($sformatf("vec%0d_powered", i), 32'(powered), 32'(e.pw));
            check($sformatf("vec%0d_color_en", i), 32'(color_en), 32'(e.cen));
            check($sformatf("vec%0d_color_sel", i), 32'(color_sel), 32'(e.csel));
            check($sformatf("vec%0d_bad_op", i), 32'(bad_op), 32'(e.bad));
            check($sformatf("vec%0d_drop_cnt", i), 32'(drop_cnt), 32'(e.drop));
        end
        tick();
        check("bad_op_one_cycle", 32'(bad_op), 32'd0);

        // Back-to-back colour commands: second is accepted on the very next edge.
        issue(4'b0110);
        check("b2b_ready_held", 32'(op_ready), 32'd1);
        issue(4'b0101);
        check("b2b_color_first", 32'(color_sel), 32'd2);
        tick();
        check("b2b_color_second", 32'(color_sel), 32'd1);
        check("b2b_color_en", 32'(color_en), 32'd1);

        // Two sounds back-to-back: second waits, one idle clock between plays.
        issue(4'b1010);
        issue(4'b1000);
        for (int k = 0; k <= 2 * SOUND_CYCLES + 1; k++) begin
            if (k < SOUND_CYCLES)
                tq.push_back('{1'b1, 2'd2, 3'b000, 1'b0});
            else if (k == SOUND_CYCLES)
                tq.push_back('{1'b0, 2'd2, 3'b000, 1'b1});
            else if (k <= 2 * SOUND_CYCLES)
                tq.push_back('{1'b1, 2'd0, 3'b000, 1'b1});
            else
                tq.push_back('{1'b0, 2'd0, 3'b000, 1'b1});
        end
        run_trace("snd");

        // Fog, then a sound concurrently, then wave hands queued behind the fog.
        issue(4'b1110);
        issue(4'b1001);
        check("fog_first_cycle", 32'(fx_en), 32'd4);
        issue(4'b1100);
        for (int k = 0; k <= FOG_CYCLES + FX_CYCLES; k++) begin
            trace_t t;
            t.s_en  = (k < SOUND_CYCLES);
            t.s_sel = 2'd1;
            if (k <= FOG_CYCLES - 2)           t.fx = 3'b100;
            else if (k == FOG_CYCLES - 1)      t.fx = 3'b000;
            else if (k < FOG_CYCLES + FX_CYCLES) t.fx = 3'b001;
            else                               t.fx = 3'b000;
            t.rdy = (k >= FOG_CYCLES - 1);
            tq.push_back(t);
        end
        run_trace("fx");

        // RESET command mid-playback clears everything but drop_cnt.
        issue(4'b0110);
        issue(4'b1001);
        issue(4'b1101);
        issue(4'b0001);
        check("pre_reset_sound", 32'(sound_en), 32'd1);
        check("pre_reset_jaw", 32'(fx_en), 32'd2);
        tick();
        check("cmd_reset_powered", 32'(powered), 32'd0);
        check("cmd_reset_outputs", 32'({color_en, color_sel, sound_en, sound_sel, fx_en}), 32'd0);
        check("cmd_reset_drop_kept", 32'(drop_cnt), 32'd4);
        issue(4'b1000);
        tick();
        check("off_sound_bad_op", 32'(bad_op), 32'd1);
        check("off_sound_drop", 32'(drop_cnt), 32'd5);
        check("off_sound_silent", 32'(sound_en), 32'd0);

        // Saturation: stream undefined opcodes for 300 clocks.
        op_valid = 1'b1;
        opcode   = 4'b1111;
        repeat (300) tick();
        check("sat_drop_cnt", 32'(drop_cnt), 32'd255);
        check("sat_bad_op", 32'(bad_op), 32'd1);
        op_valid = 1'b0;
        tick();
        issue(4'b0010);
        tick();
        check("sat_no_wrap", 32'(drop_cnt), 32'd255);

        // Asynchronous reset during fog.
        issue(4'b0000);
        issue(4'b1110);
        repeat (3) tick();
        check("fog_running", 32'(fx_en), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_fx_clear", 32'(fx_en), 32'd0);
        check("async_drop_clear", 32'(drop_cnt), 32'd0);
        check("async_powered", 32'(powered), 32'd0);
        check("async_op_ready", 32'(op_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rerelease_op_ready", 32'(op_ready), 32'd1);
        check("rerelease_fx", 32'(fx_en), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
